// File: rtl/payload_frame_buffer_if.sv
// Byte-stream bundle for the payload frame buffer: parser-side input stream
// and consumer-side valid/ready output stream.
interface payload_frame_buffer_if;
    logic [7:0] payload;
    logic       payload_valid;
    logic       payload_last;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (
        output payload, payload_valid, payload_last, m_ready,
        input  m_data, m_valid, m_last
    );

    modport slave (
        input  payload, payload_valid, payload_last, m_ready,
        output m_data, m_valid, m_last
    );
endinterface

// File: rtl/payload_frame_buffer.sv
// Store-and-forward UDP payload buffer: frames land in a circular byte RAM and
// are released only once complete; frames that do not fit are dropped whole.
module payload_frame_buffer #(
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned MAX_FRAMES = 16,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    payload_frame_buffer_if.slave         bus,
    output logic [$clog2(MAX_FRAMES):0]   frames_pending,
    output logic [15:0]                   drop_count,
    output logic                          drop_pulse
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned FA_W   = $clog2(MAX_FRAMES);

    typedef logic [ADDR_W:0] ptr_t;
    typedef logic [FA_W:0]   lf_ptr_t;
    typedef logic [LEN_W-1:0] len_t;

    localparam ptr_t    BUF_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam lf_ptr_t LF_FULL  = {1'b1, {FA_W{1'b0}}};

    typedef enum logic {W_ACCEPT, W_DISCARD} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_state_e;

    logic [7:0] mem [DEPTH];
    len_t       len_mem [MAX_FRAMES];

    ptr_t      wr_ptr_q, wr_ptr_d;
    ptr_t      commit_ptr_q, commit_ptr_d;
    ptr_t      rd_ptr_q, rd_ptr_d;
    len_t      run_len_q, run_len_d;
    lf_ptr_t   lf_wptr_q, lf_wptr_d;
    lf_ptr_t   lf_rptr_q, lf_rptr_d;
    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    len_t      remaining_q, remaining_d;
    logic [7:0] m_data_q, m_data_d;
    logic       m_valid_q, m_valid_d;
    logic       m_last_q, m_last_d;
    logic       drop_pulse_q, drop_pulse_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic [7:0] rdata_q;

    ptr_t    used;
    lf_ptr_t lf_count;
    logic    buf_full, lf_full, lf_empty;
    logic    mem_we, lf_push, lf_pop, rd_en, drop_frame;

    assign used     = wr_ptr_q - rd_ptr_q;
    assign buf_full = (used == BUF_FULL);
    assign lf_count = lf_wptr_q - lf_rptr_q;
    assign lf_full  = (lf_count == LF_FULL);
    assign lf_empty = (lf_count == '0);

    // Write side: bytes are stored speculatively; a drop rewinds to the last commit.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        run_len_d    = run_len_q;
        wr_state_d   = wr_state_q;
        lf_wptr_d    = lf_wptr_q;
        mem_we       = 1'b0;
        lf_push      = 1'b0;
        drop_frame   = 1'b0;
        case (wr_state_q)
            W_ACCEPT: begin
                if (bus.payload_valid) begin
                    if (buf_full) begin
                        if (bus.payload_last) drop_frame = 1'b1;
                        else                  wr_state_d = W_DISCARD;
                    end else begin
                        mem_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_q + ptr_t'(1);
                        run_len_d = run_len_q + len_t'(1);
                        if (bus.payload_last) begin
                            if (!lf_full) begin
                                lf_push      = 1'b1;
                                lf_wptr_d    = lf_wptr_q + lf_ptr_t'(1);
                                commit_ptr_d = wr_ptr_q + ptr_t'(1);
                                run_len_d    = '0;
                            end else begin
                                drop_frame = 1'b1;
                            end
                        end
                    end
                end
            end
            W_DISCARD: begin
                if (bus.payload_valid && bus.payload_last) drop_frame = 1'b1;
            end
            default: wr_state_d = W_ACCEPT;
        endcase
        if (drop_frame) begin
            wr_ptr_d   = commit_ptr_q;
            run_len_d  = '0;
            wr_state_d = W_ACCEPT;
        end
        drop_pulse_d = drop_frame;
        drop_count_d = (drop_frame && drop_count_q != '1) ? drop_count_q + 16'd1 : drop_count_q;
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_ptr_d    = rd_ptr_q;
        lf_rptr_d   = lf_rptr_q;
        remaining_d = remaining_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        lf_pop      = 1'b0;
        rd_en       = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (!lf_empty) begin
                    lf_pop      = 1'b1;
                    lf_rptr_d   = lf_rptr_q + lf_ptr_t'(1);
                    remaining_d = len_mem[lf_rptr_q[FA_W-1:0]];
                    rd_en       = 1'b1;
                    rd_ptr_d    = rd_ptr_q + ptr_t'(1);
                    rd_state_d  = R_FETCH;
                end
            end
            R_FETCH: begin
                m_data_d   = rdata_q;
                m_valid_d  = 1'b1;
                m_last_d   = (remaining_q == len_t'(1));
                rd_state_d = R_STREAM;
            end
            R_STREAM: begin
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d   = 1'b0;
                    remaining_d = remaining_q - len_t'(1);
                    if (m_last_q) begin
                        m_last_d   = 1'b0;
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_en      = 1'b1;
                        rd_ptr_d   = rd_ptr_q + ptr_t'(1);
                        rd_state_d = R_FETCH;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            run_len_q    <= '0;
            lf_wptr_q    <= '0;
            lf_rptr_q    <= '0;
            wr_state_q   <= W_ACCEPT;
            rd_state_q   <= R_IDLE;
            remaining_q  <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            run_len_q    <= run_len_d;
            lf_wptr_q    <= lf_wptr_d;
            lf_rptr_q    <= lf_rptr_d;
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            remaining_q  <= remaining_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Read-first RAM: the read issued this cycle sees the old contents.
    always_ff @(posedge clk) begin
        if (mem_we)  mem[wr_ptr_q[ADDR_W-1:0]] <= bus.payload;
        if (rd_en)   rdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
        if (lf_push) len_mem[lf_wptr_q[FA_W-1:0]] <= run_len_q + len_t'(1);
    end

    assign bus.m_data     = m_data_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_last     = m_last_q;
    assign frames_pending = lf_count;
    assign drop_count     = drop_count_q;
    assign drop_pulse     = drop_pulse_q;
endmodule

// File: tb/tb_payload_frame_buffer.sv
// Directed bench for payload_frame_buffer using a small buffer (16 bytes,
// 4-entry length FIFO) so overflow and wrap cases are short.
module tb_payload_frame_buffer;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned MAX_FRAMES = 4;
    localparam int unsigned LEN_W      = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [$clog2(MAX_FRAMES):0] frames_pending;
    logic [15:0] drop_count;
    logic        drop_pulse;

    payload_frame_buffer_if bus();

    payload_frame_buffer #(
        .DEPTH(DEPTH),
        .MAX_FRAMES(MAX_FRAMES),
        .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus),
        .frames_pending(frames_pending),
        .drop_count(drop_count),
        .drop_pulse(drop_pulse)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [8:0] rx_q[$];
    int drop_pulses = 0;

    // Accepted beats are {m_last, m_data}; sampled mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (resetn && bus.m_valid && bus.m_ready) rx_q.push_back({bus.m_last, bus.m_data});
        if (resetn && drop_pulse) drop_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        bus.payload = '0;
        bus.payload_valid = 1'b0;
        bus.payload_last = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] first, input int len);
        for (int i = 0; i < len; i++) begin
            bus.payload = first + 8'(i);
            bus.payload_valid = 1'b1;
            bus.payload_last = (i == len - 1);
            tick();
        end
        bus.payload_valid = 1'b0;
        bus.payload_last = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (rx_q.size() >= target) ok = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.payload = '0;
        bus.payload_valid = 1'b0;
        bus.payload_last = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
        checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", bus.m_data); end
        checks++; if (frames_pending !== '0) begin errors++; $display("FAIL reset_frames_pending: got %0d want 0", frames_pending); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop_pulse: got %b want 0", drop_pulse); end
        resetn = 1'b1;
        tick();
        tick();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_m_valid: got %b want 0", bus.m_valid); end
    endtask

    task automatic test_single_frame();
        int base;
        bit ok;
        logic [8:0] exp;
        apply_reset();
        bus.m_ready = 1'b1;
        base = rx_q.size();
        send_frame(8'h01, 10);
        checks++; if (frames_pending !== 3'd1) begin errors++; $display("FAIL single_fp_after_commit: got %0d want 1", frames_pending); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_c1: got %b want 0", bus.m_valid); end
        tick();
        checks++; if (frames_pending !== 3'd0) begin errors++; $display("FAIL single_fp_after_pop: got %0d want 0", frames_pending); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_c2: got %b want 0", bus.m_valid); end
        tick();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h01 || bus.m_last !== 1'b0) begin
            errors++; $display("FAIL single_first_beat_c3: got v=%b d=%h l=%b want v=1 d=01 l=0", bus.m_valid, bus.m_data, bus.m_last);
        end
        wait_beats(base + 10, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_beats_timeout: got %0d want 10", rx_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 10; i++) begin
                exp = {(i == 9), 8'(i + 1)};
                checks++; if (rx_q[base + i] !== exp) begin errors++; $display("FAIL single_beat%0d: got %h want %h", i, rx_q[base + i], exp); end
            end
        end
        repeat (10) tick();
        checks++; if (rx_q.size() !== base + 10) begin errors++; $display("FAIL single_extra_beats: got %0d want 10", rx_q.size() - base); end
    endtask

    task automatic test_backpressure();
        int base;
        bit ok;
        logic [8:0] exp;
        apply_reset();
        base = rx_q.size();
        send_frame(8'h20, 4);
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h20 || bus.m_last !== 1'b0) begin
                errors++; $display("FAIL stall_hold_cycle%0d: got v=%b d=%h l=%b want v=1 d=20 l=0", i, bus.m_valid, bus.m_data, bus.m_last);
            end
            tick();
        end
        bus.m_ready = 1'b1;
        wait_beats(base + 4, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_beats_timeout: got %0d want 4", rx_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                exp = {(i == 3), 8'h20 + 8'(i)};
                checks++; if (rx_q[base + i] !== exp) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", i, rx_q[base + i], exp); end
            end
        end
    endtask

    task automatic test_overflow();
        int base, dbase;
        bit ok;
        logic [8:0] exp;
        apply_reset();
        base = rx_q.size();
        dbase = drop_pulses;
        send_frame(8'h30, 12);
        checks++; if (frames_pending !== 3'd1) begin errors++; $display("FAIL ovf_fp_first: got %0d want 1", frames_pending); end
        // Only 5 bytes of space remain once the first read has been issued.
        send_frame(8'h80, 10);
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL ovf_drop_pulse: got %b want 1", drop_pulse); end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drop_count: got %0d want 1", drop_count); end
        tick();
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width: got %b want 0", drop_pulse); end
        checks++; if (drop_pulses - dbase !== 1) begin errors++; $display("FAIL ovf_pulse_count: got %0d want 1", drop_pulses - dbase); end
        bus.m_ready = 1'b1;
        wait_beats(base + 12, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_beats_timeout: got %0d want 12", rx_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 12; i++) begin
                exp = {(i == 11), 8'h30 + 8'(i)};
                checks++; if (rx_q[base + i] !== exp) begin errors++; $display("FAIL ovf_beat%0d: got %h want %h", i, rx_q[base + i], exp); end
            end
        end
        repeat (30) tick();
        checks++; if (rx_q.size() !== base + 12) begin errors++; $display("FAIL ovf_total_beats: got %0d want 12", rx_q.size() - base); end
    endtask

    task automatic test_len_fifo_full();
        int base;
        bit ok;
        logic [7:0] first;
        logic [8:0] exp;
        apply_reset();
        base = rx_q.size();
        // Frame 0 is popped into the read FSM at once, so the FIFO fills after frame 4.
        for (int k = 0; k < 5; k++) send_frame(8'((k + 1) * 16), 2);
        checks++; if (frames_pending !== 3'd4) begin errors++; $display("FAIL lff_fp_full: got %0d want 4", frames_pending); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL lff_no_drop_yet: got %0d want 0", drop_count); end
        send_frame(8'h60, 2);
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL lff_drop_pulse: got %b want 1", drop_pulse); end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL lff_drop_count: got %0d want 1", drop_count); end
        bus.m_ready = 1'b1;
        wait_beats(base + 10, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lff_beats_timeout: got %0d want 10", rx_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 10; i++) begin
                first = 8'((i / 2 + 1) * 16);
                exp = {(i % 2 == 1), first + 8'(i % 2)};
                checks++; if (rx_q[base + i] !== exp) begin errors++; $display("FAIL lff_beat%0d: got %h want %h", i, rx_q[base + i], exp); end
            end
        end
        repeat (30) tick();
        checks++; if (rx_q.size() !== base + 10) begin errors++; $display("FAIL lff_total_beats: got %0d want 10", rx_q.size() - base); end
    endtask

    task automatic test_boundaries();
        int base;
        bit ok;
        apply_reset();
        bus.m_ready = 1'b1;
        base = rx_q.size();
        send_frame(8'h90, 20);
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL oversize_drop_pulse: got %b want 1", drop_pulse); end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL oversize_drop_count: got %0d want 1", drop_count); end
        checks++; if (frames_pending !== 3'd0) begin errors++; $display("FAIL oversize_fp: got %0d want 0", frames_pending); end
        send_frame(8'hC5, 1);
        wait_beats(base + 1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL onebyte_timeout: got %0d want 1", rx_q.size() - base); end
        if (ok) begin
            checks++; if (rx_q[base] !== 9'h1C5) begin errors++; $display("FAIL onebyte_beat: got %h want 1c5", rx_q[base]); end
        end
        repeat (20) tick();
        checks++; if (rx_q.size() !== base + 1) begin errors++; $display("FAIL onebyte_total_beats: got %0d want 1", rx_q.size() - base); end
    endtask

    task automatic test_wraparound();
        int base;
        bit ok;
        logic [8:0] exp;
        apply_reset();
        bus.m_ready = 1'b1;
        base = rx_q.size();
        for (int f = 0; f < 20; f++) begin
            send_frame(8'(f * 7), 7);
            repeat (10) tick();
        end
        wait_beats(base + 140, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_beats_timeout: got %0d want 140", rx_q.size() - base); end
        if (ok) begin
            for (int n = 0; n < 140; n++) begin
                exp = {(n % 7 == 6), 8'(n)};
                checks++; if (rx_q[base + n] !== exp) begin errors++; $display("FAIL wrap_beat%0d: got %h want %h", n, rx_q[base + n], exp); end
            end
        end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL wrap_drop_count: got %0d want 0", drop_count); end
    endtask

    task automatic test_back_to_back();
        int base;
        int last_idx, next_idx;
        bit ok;
        logic [8:0] exp [4];
        apply_reset();
        bus.m_ready = 1'b1;
        base = rx_q.size();
        send_frame(8'h50, 2);
        send_frame(8'h60, 2);
        last_idx = -1;
        next_idx = -1;
        for (int i = 0; i < 60; i++) begin
            if (last_idx < 0 && bus.m_valid && bus.m_ready && bus.m_last) last_idx = i;
            else if (last_idx >= 0 && next_idx < 0 && bus.m_valid) next_idx = i;
            tick();
        end
        checks++;
        if (last_idx < 0 || next_idx - last_idx != 3) begin
            errors++; $display("FAIL b2b_gap: got last=%0d next=%0d want gap 3", last_idx, next_idx);
        end
        wait_beats(base + 4, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_beats_timeout: got %0d want 4", rx_q.size() - base); end
        exp[0] = 9'h050; exp[1] = 9'h151; exp[2] = 9'h060; exp[3] = 9'h161;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (rx_q[base + i] !== exp[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, rx_q[base + i], exp[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        int base, nb;
        bit ok;
        logic [8:0] exp;
        apply_reset();
        bus.m_ready = 1'b1;
        base = rx_q.size();
        send_frame(8'hA0, 8);
        send_frame(8'hB0, 8);
        checks++; if (frames_pending !== 3'd1) begin errors++; $display("FAIL rms_fp_before: got %0d want 1", frames_pending); end
        checks++; if (rx_q.size() - base >= 8) begin errors++; $display("FAIL rms_not_mid_stream: got %0d beats want <8", rx_q.size() - base); end
        resetn = 1'b0;
        #1;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rms_m_valid: got %b want 0", bus.m_valid); end
        checks++; if (frames_pending !== 3'd0) begin errors++; $display("FAIL rms_fp: got %0d want 0", frames_pending); end
        tick();
        tick();
        resetn = 1'b1;
        tick();
        nb = rx_q.size();
        repeat (20) tick();
        checks++; if (rx_q.size() !== nb) begin errors++; $display("FAIL rms_stale_beats: got %0d want 0", rx_q.size() - nb); end
        send_frame(8'hD0, 5);
        wait_beats(nb + 5, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rms_beats_timeout: got %0d want 5", rx_q.size() - nb); end
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                exp = {(i == 4), 8'hD0 + 8'(i)};
                checks++; if (rx_q[nb + i] !== exp) begin errors++; $display("FAIL rms_beat%0d: got %h want %h", i, rx_q[nb + i], exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_len_fifo_full();
        test_boundaries();
        test_wraparound();
        test_back_to_back();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
